// File: rtl/fir_seq_pkg.sv
// Shared types and defaults for the FIR sample sequencer.
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_DATA_SIZE      = 16;
  localparam int unsigned DEFAULT_FIFO_DEPTH     = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2048;
  localparam int unsigned DEFAULT_CNT_WIDTH      = 16;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_seq_fifo.sv
// Small synchronous FIFO buffering input samples ahead of the FIR.
module fir_seq_fifo
  import fir_seq_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = DEFAULT_DATA_SIZE,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 pop_i,
  output logic [DATA_SIZE-1:0] head_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 push_ok, pop_ok;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    push_ok  = push_i && !full_q;
    pop_ok   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d   = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/fir_sample_sequencer.sv
// Feeds buffered samples to the FIR one at a time, collects each result with a
// timeout guard, and keeps latency / completion status for software.
module fir_sample_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned DATA_SIZE      = DEFAULT_DATA_SIZE,
  parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [DATA_SIZE-1:0]   s_data_i,
  output logic                   fir_valid_strobe_o,
  output logic [DATA_SIZE-1:0]   fir_sample_o,
  input  logic                   fir_valid_strobe_i,
  input  logic [2*DATA_SIZE-1:0] fir_y_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [2*DATA_SIZE-1:0] m_data_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic [CNT_WIDTH-1:0]   last_latency_o,
  output logic [CNT_WIDTH-1:0]   sample_count_o,
  input  logic                   clear_i
);

  localparam int unsigned Y_W    = 2 * DATA_SIZE;
  localparam int unsigned LAT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WIDE_W = (LAT_W > CNT_WIDTH) ? LAT_W : CNT_WIDTH;
  localparam logic [WIDE_W-1:0] CNT_MAX = WIDE_W'({CNT_WIDTH{1'b1}});

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] sample_q, sample_d;
  logic                 strobe_q, strobe_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic                 m_valid_q, m_valid_d;
  logic [Y_W-1:0]       m_data_q, m_data_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] last_lat_q, last_lat_d;
  logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [DATA_SIZE-1:0] fifo_head;
  logic [LAT_W-1:0]     lat_plus1;
  logic [WIDE_W-1:0]    lat_wide;
  logic [CNT_WIDTH-1:0] lat_sat;

  fir_seq_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (s_valid_i),
    .data_i (s_data_i),
    .pop_i  (fifo_pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Latency as reported: WAIT cycles so far including this one, saturated.
  always_comb begin
    lat_plus1 = lat_cnt_q + LAT_W'(1);
    lat_wide  = WIDE_W'(lat_plus1);
    lat_sat   = (lat_wide > CNT_MAX) ? {CNT_WIDTH{1'b1}} : CNT_WIDTH'(lat_wide);
  end

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    lat_cnt_d    = lat_cnt_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    timeout_d    = timeout_q;
    last_lat_d   = last_lat_q;
    sample_cnt_d = sample_cnt_q;
    fifo_pop     = 1'b0;

    if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && (!m_valid_q || m_ready_i)) begin
          state_d   = ISSUE;
          fifo_pop  = 1'b1;
          sample_d  = fifo_head;
          lat_cnt_d = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        lat_cnt_d = lat_plus1;
        // A result arriving on the threshold cycle still counts as success.
        if (fir_valid_strobe_i) begin
          m_data_d     = fir_y_i;
          m_valid_d    = 1'b1;
          last_lat_d   = lat_sat;
          sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
          state_d      = IDLE;
        end else if (lat_plus1 == LAT_W'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status clear overrides any same-cycle update; the stream is untouched.
    if (clear_i) begin
      timeout_d    = 1'b0;
      last_lat_d   = '0;
      sample_cnt_d = '0;
    end

    strobe_d = (state_d == ISSUE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sample_q     <= '0;
      strobe_q     <= 1'b0;
      lat_cnt_q    <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      last_lat_q   <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      strobe_q     <= strobe_d;
      lat_cnt_q    <= lat_cnt_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      last_lat_q   <= last_lat_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign s_ready_o          = !fifo_full;
  assign fir_valid_strobe_o = strobe_q;
  assign fir_sample_o       = sample_q;
  assign m_valid_o          = m_valid_q;
  assign m_data_o           = m_data_q;
  assign busy_o             = busy_q;
  assign timeout_o          = timeout_q;
  assign last_latency_o     = last_lat_q;
  assign sample_count_o     = sample_cnt_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Self-checking bench for fir_sample_sequencer: vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_fir_sample_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready_o;
  logic [DW-1:0] s_data;
  logic          fir_valid_strobe_o;
  logic [DW-1:0] fir_sample_o;
  logic          fir_strobe_i;
  logic [31:0]   fir_y_i;
  logic          m_valid_o;
  logic          m_ready;
  logic [31:0]   m_data_o;
  logic          busy_o;
  logic          timeout_o;
  logic [CW-1:0] last_latency_o;
  logic [CW-1:0] sample_count_o;
  logic          clear;

  fir_sample_sequencer #(
    .DATA_SIZE     (DW),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .s_valid_i         (s_valid),
    .s_ready_o         (s_ready_o),
    .s_data_i          (s_data),
    .fir_valid_strobe_o(fir_valid_strobe_o),
    .fir_sample_o      (fir_sample_o),
    .fir_valid_strobe_i(fir_strobe_i),
    .fir_y_i           (fir_y_i),
    .m_valid_o         (m_valid_o),
    .m_ready_i         (m_ready),
    .m_data_o          (m_data_o),
    .busy_o            (busy_o),
    .timeout_o         (timeout_o),
    .last_latency_o    (last_latency_o),
    .sample_count_o    (sample_count_o),
    .clear_i           (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sample;
    int          fir_lat;
    logic [31:0] fir_y;
    logic [31:0] exp_data;
    logic [15:0] exp_lat;
  } vec_t;

  int checks;
  int failures;
  int cycle;
  int strobe_cnt;
  int last_issue_cycle;
  int accepted;
  int delivered;
  int fir_lat;
  int fir_cnt;
  int last_fir_lat;
  bit sb_en;
  bit fir_use_fixed;
  logic [31:0] fir_y_fixed;
  logic [15:0] last_issued;
  logic [31:0] exp_q[$];
  int issue_cycles[$];

  function automatic logic [31:0] fir_fn(input logic [15:0] x);
    return ({16'h0, x} * 32'd3) ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes, hold stability, then model the FIR core.
  task automatic tick();
    bit hs, acc, pend;
    logic [31:0] hs_data;
    logic [15:0] acc_data;
    hs       = m_valid_o && m_ready;
    hs_data  = m_data_o;
    acc      = s_valid && s_ready_o;
    acc_data = s_data;
    pend     = m_valid_o && !m_ready;
    @(posedge clk);
    #1;
    cycle++;
    if (acc) begin
      accepted++;
      if (sb_en) exp_q.push_back(fir_fn(acc_data));
    end
    if (hs) begin
      delivered++;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_extra: got 0x%0h expected no result", hs_data);
        end else begin
          check("stream_data", hs_data, exp_q.pop_front());
        end
      end
    end
    if (pend) begin
      check("hold_valid", m_valid_o, 1'b1);
      check("hold_data", m_data_o, hs_data);
    end
    if (fir_valid_strobe_o) begin
      strobe_cnt++;
      last_issue_cycle = cycle;
      issue_cycles.push_back(cycle);
      last_issued  = fir_sample_o;
      fir_cnt      = fir_lat;
      fir_strobe_i = 1'b0;
    end else if (fir_cnt > 0) begin
      fir_cnt--;
      if (fir_cnt == 0) begin
        fir_strobe_i = 1'b1;
        fir_y_i      = fir_use_fixed ? fir_y_fixed : fir_fn(fir_sample_o);
        last_fir_lat = fir_lat;
      end else begin
        fir_strobe_i = 1'b0;
      end
    end else begin
      fir_strobe_i = 1'b0;
    end
  endtask

  task automatic push(input logic [15:0] x);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = x;
    while (!s_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready_o) check("push_ready", s_ready_o, 1'b1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input int budget, input string name);
    int n;
    n = 0;
    while (!m_valid_o && n < budget) begin
      tick();
      n++;
    end
    check(name, m_valid_o, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int s0, d0, a0, nxt, n, ci;
    bit a;

    tbl[0] = '{16'h0042, 5,  32'h0000_1234, 32'h0000_1234, 16'd5};
    tbl[1] = '{16'h7fff, 1,  32'hdead_beef, 32'hdead_beef, 16'd1};
    tbl[2] = '{16'hffff, 15, 32'hffff_ffff, 32'hffff_ffff, 16'd15};
    tbl[3] = '{16'h0000, 16, 32'h0000_0001, 32'h0000_0001, 16'd16};
    tbl[4] = '{16'h8001, 2,  32'h1234_5678, 32'h1234_5678, 16'd2};

    checks = 0; failures = 0; cycle = 0; strobe_cnt = 0; last_issue_cycle = 0;
    accepted = 0; delivered = 0; fir_lat = 0; fir_cnt = 0; last_fir_lat = 0;
    sb_en = 1'b0; fir_use_fixed = 1'b0; fir_y_fixed = '0; last_issued = '0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; fir_strobe_i = 1'b0; fir_y_i = '0;
    m_ready = 1'b0; clear = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid_o, 1'b0);
    check("rst_strobe", fir_valid_strobe_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_timeout", timeout_o, 1'b0);
    check("rst_count", sample_count_o, 16'd0);
    check("rst_latency", last_latency_o, 16'd0);
    rst = 1'b0;
    tick();
    check("rst_s_ready", s_ready_o, 1'b1);
    check("rst_m_data", m_data_o, 32'd0);
    check("rst_sample", fir_sample_o, 16'd0);

    // Vector table: one sample each, result held until a single-cycle ready
    fir_use_fixed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fir_lat     = tbl[i].fir_lat;
      fir_y_fixed = tbl[i].fir_y;
      s0 = strobe_cnt;
      push(tbl[i].sample);
      wait_mvalid(40, "tbl_wait");
      check("tbl_data", m_data_o, tbl[i].exp_data);
      check("tbl_latency", last_latency_o, tbl[i].exp_lat);
      check("tbl_count", sample_count_o, 16'(i + 1));
      check("tbl_sample", last_issued, tbl[i].sample);
      check("tbl_timeout", timeout_o, 1'b0);
      repeat (3) tick();
      check("tbl_one_strobe", strobe_cnt - s0, 1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      tick();
      check("tbl_valid_drop", m_valid_o, 1'b0);
    end

    // Burst of 8 with the consumer stalled, then drained in order
    fir_use_fixed = 1'b0;
    sb_en = 1'b1;
    fir_lat = 3;
    s0 = strobe_cnt;
    d0 = delivered;
    nxt = 1;
    for (int c = 0; c < 30; c++) begin
      s_valid = (nxt <= 8);
      s_data  = 16'(nxt);
      a = s_valid && s_ready_o;
      tick();
      if (a) nxt++;
    end
    s_valid = 1'b0;
    check("burst_accepted", nxt - 1, 5);
    check("burst_s_ready", s_ready_o, 1'b0);
    check("burst_one_strobe", strobe_cnt - s0, 1);
    check("burst_pending", m_valid_o, 1'b1);
    check("burst_first", m_data_o, fir_fn(16'h0001));
    m_ready = 1'b1;
    for (int c = 0; c < 200 && (delivered - d0) < 8; c++) begin
      s_valid = (nxt <= 8);
      s_data  = 16'(nxt);
      a = s_valid && s_ready_o;
      tick();
      if (a) nxt++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("burst_delivered", delivered - d0, 8);
    check("burst_sb_empty", exp_q.size(), 0);
    check("burst_count", sample_count_o, 16'd13);
    check("burst_strobes", strobe_cnt - s0, 8);

    // Timeout: FIR never answers
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", sample_count_o, 16'd0);
    check("clr_latency", last_latency_o, 16'd0);
    sb_en = 1'b0;
    fir_lat = 0;
    m_ready = 1'b1;
    d0 = delivered;
    s0 = strobe_cnt;
    push(16'h0aaa);
    push(16'h0bbb);
    ci = last_issue_cycle;
    check("to_first_issue", strobe_cnt - s0, 1);
    check("to_first_sample", last_issued, 16'h0aaa);
    while (cycle < ci + 16) tick();
    check("to_before", timeout_o, 1'b0);
    check("to_busy", busy_o, 1'b1);
    tick();
    check("to_at_16", timeout_o, 1'b1);
    check("to_no_valid", m_valid_o, 1'b0);
    tick();
    check("to_next_issue", fir_valid_strobe_o, 1'b1);
    check("to_next_sample", fir_sample_o, 16'h0bbb);
    repeat (20) tick();
    check("to_sticky", timeout_o, 1'b1);
    check("to_no_result", delivered - d0, 0);
    check("to_count", sample_count_o, 16'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("to_cleared", timeout_o, 1'b0);

    // Spurious FIR strobes in IDLE and in ISSUE
    fir_strobe_i = 1'b1;
    fir_y_i = 32'hbad0_bad0;
    tick();
    repeat (3) tick();
    check("sp_idle_valid", m_valid_o, 1'b0);
    check("sp_idle_count", sample_count_o, 16'd0);
    check("sp_idle_busy", busy_o, 1'b0);
    push(16'h0ccc);
    n = 0;
    while (!fir_valid_strobe_o && n < 10) begin
      tick();
      n++;
    end
    check("sp_issue_seen", fir_valid_strobe_o, 1'b1);
    fir_strobe_i = 1'b1;
    fir_y_i = 32'hbad1_bad1;
    tick();
    repeat (4) tick();
    check("sp_issue_valid", m_valid_o, 1'b0);
    check("sp_issue_count", sample_count_o, 16'd0);
    check("sp_issue_latency", last_latency_o, 16'd0);
    check("sp_issue_busy", busy_o, 1'b1);
    repeat (20) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Asynchronous reset during WAIT with 3 samples queued
    s0 = strobe_cnt;
    push(16'h0011);
    push(16'h0012);
    push(16'h0013);
    push(16'h0014);
    repeat (2) tick();
    check("ar_busy_before", busy_o, 1'b1);
    check("ar_one_issue", strobe_cnt - s0, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_m_valid", m_valid_o, 1'b0);
    check("ar_busy", busy_o, 1'b0);
    check("ar_strobe", fir_valid_strobe_o, 1'b0);
    check("ar_sample", fir_sample_o, 16'd0);
    check("ar_timeout", timeout_o, 1'b0);
    check("ar_count", sample_count_o, 16'd0);
    fir_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fir_strobe_i = 1'b1;
    fir_y_i = 32'h0000_5555;
    tick();
    repeat (6) tick();
    check("ar_late_valid", m_valid_o, 1'b0);
    check("ar_fifo_empty", strobe_cnt - s0, 1);
    check("ar_late_count", sample_count_o, 16'd0);
    check("ar_s_ready", s_ready_o, 1'b1);
    check("ar_idle", busy_o, 1'b0);

    // FIR latency 1, consumer always ready: one issue every 3 cycles
    fir_lat = 1;
    m_ready = 1'b1;
    sb_en = 1'b1;
    issue_cycles.delete();
    d0 = delivered;
    push(16'h0021);
    push(16'h0022);
    push(16'h0023);
    push(16'h0024);
    for (int c = 0; c < 40 && (delivered - d0) < 4; c++) begin
      tick();
      if (m_valid_o) check("lat1_latency", last_latency_o, 16'd1);
    end
    check("lat1_delivered", delivered - d0, 4);
    check("lat1_issues", issue_cycles.size(), 4);
    for (int i = 1; i < 4 && i < issue_cycles.size(); i++) begin
      check("lat1_spacing", issue_cycles[i] - issue_cycles[i-1], 3);
    end
    check("lat1_count", sample_count_o, 16'd4);

    // Clear coinciding with a completion: status cleared, result delivered
    fir_lat = 2;
    m_ready = 1'b0;
    push(16'h0321);
    n = 0;
    while (!fir_strobe_i && n < 20) begin
      tick();
      n++;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrc_valid", m_valid_o, 1'b1);
    check("clrc_data", m_data_o, fir_fn(16'h0321));
    check("clrc_count", sample_count_o, 16'd0);
    check("clrc_latency", last_latency_o, 16'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("clrc_sb_empty", exp_q.size(), 0);

    // Randomized traffic against the reference queue
    a0 = accepted;
    d0 = delivered;
    for (int c = 0; c < 400; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      fir_lat = int'($urandom_range(1, 12));
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy_o || m_valid_o) && n < 500) begin
      tick();
      n++;
    end
    check("rnd_sb_empty", exp_q.size(), 0);
    check("rnd_delivered", delivered - d0, accepted - a0);
    check("rnd_count", sample_count_o, 16'(accepted - a0));
    check("rnd_latency", last_latency_o, 16'(last_fir_lat));
    check("rnd_timeout", timeout_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_sample_sequencer.md
Name: fir_sample_sequencer

Overview:
- Sequences the FIR filter datapath: accepts input samples over a valid/ready stream and buffers them in a small FIFO.
- Issues exactly one single-cycle sample strobe to the FIR, waits for its result strobe, then returns the filter output over a valid/ready stream.
- Guards the FIR with a timeout.
- Exposes per-sample latency and sample-count status for software/debug.
- Sits between the sample source (ADC/bus side) and the FIR core.

Parameters:
DATA_SIZE, 16, input sample width; result width is 2*DATA_SIZE
FIFO_DEPTH, 4, input FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 2048, max WAIT cycles before abandoning a sample (>=2)
CNT_WIDTH, 16, width of latency and sample counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
s_valid_i  in  1  input sample valid
s_ready_o  out  1  input ready (= FIFO not full)
s_data_i  in  DATA_SIZE  input sample
fir_valid_strobe_o  out  1  one-cycle strobe to FIR
fir_sample_o  out  DATA_SIZE  sample to FIR, stable from strobe until result or timeout
fir_valid_strobe_i  in  1  FIR result strobe
fir_y_i  in  2*DATA_SIZE  FIR result
m_valid_o  out  1  result valid
m_ready_i  in  1  result consumer ready
m_data_o  out  2*DATA_SIZE  captured result
busy_o  out  1  high in ISSUE or WAIT
timeout_o  out  1  sticky timeout flag
last_latency_o  out  CNT_WIDTH  latency of last completed sample
sample_count_o  out  CNT_WIDTH  completed samples, wraps modulo 2^CNT_WIDTH
clear_i  in  1  synchronous clear of status outputs

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs are 0; s_ready_o is 1 once reset is released.
  - FIFO is emptied, FSM is in IDLE, counters are 0.
  - Reset mid-operation abandons any in-flight sample; a later fir_valid_strobe_i is ignored.
- FIFO:
  - Push when s_valid_i && s_ready_o; s_ready_o = !full.
  - Pop occurs only on the IDLE->ISSUE transition.
  - Simultaneous push and pop is legal when not full; the count is unchanged.
  - Data order is preserved.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Go to ISSUE when the FIFO is not empty and the output slot is free (!m_valid_o || m_ready_i).
  - On that transition: pop the FIFO head into the fir_sample_o register; clear the latency counter to 0.
- ISSUE:
  - Exactly one cycle with fir_valid_strobe_o = 1 (registered, Moore).
  - Always goes to WAIT.
- WAIT:
  - Latency counter increments each cycle.
  - If fir_valid_strobe_i: m_data_o <= fir_y_i; m_valid_o <= 1; last_latency_o <= counter+1; sample_count_o += 1; go to IDLE.
  - Else if counter+1 == TIMEOUT_CYCLES: timeout_o <= 1; sample dropped (no result, count unchanged); go to IDLE.
  - A result strobe in the same cycle as the timeout threshold counts as success.
- Latency definition:
  - Cycles from the ISSUE cycle (exclusive) to the strobe cycle (inclusive).
  - A FIR answering in the cycle after ISSUE gives latency 1.
  - last_latency_o saturates at 2^CNT_WIDTH-1.
- Outside WAIT, fir_valid_strobe_i and fir_y_i are ignored.
- Output handshake:
  - m_valid_o is held with m_data_o stable until m_ready_i; it falls the cycle after the handshake unless a new capture occurs.
  - At most one result is pending.
- Best-case throughput is one sample per 3 cycles when the FIR latency is 1 and m_ready_i stays high.
- clear_i:
  - Zeroes timeout_o, last_latency_o and sample_count_o next cycle.
  - Does not affect FSM, FIFO or output stream.
  - If clear_i coincides with a completion or timeout, the clear wins for status; the result is still delivered.

Decomposition:
- Package fir_seq_pkg holds:
  - the state enum type (IDLE, ISSUE, WAIT);
  - default constants for FIFO_DEPTH and TIMEOUT_CYCLES;
  - the pointer-width function $clog2(FIFO_DEPTH).
- Sub-module fir_seq_fifo: synchronous FIFO with push/pop/full/empty/head, same clock and reset.

Test Plan:
- Reset, then push 0x0042 with a FIR model of latency 5 returning 0x0000_1234 -> exactly one fir_valid_strobe_o with fir_sample_o=0x0042; m_valid_o with m_data_o=0x0000_1234; last_latency_o=5; sample_count_o=1.
- Burst of 8 samples 0x01..0x08 with m_ready_i held low:
  - first result 0x01 stays pending and stable;
  - a second strobe is never issued while the result is pending;
  - s_ready_o drops after 1 issued + 4 buffered samples.
  - Raising m_ready_i then drains all 8 results in order; sample_count_o=8.
- TIMEOUT_CYCLES=16, FIR never responds -> timeout_o=1 exactly 16 cycles after ISSUE with no m_valid_o; the next queued sample is issued immediately; timeout_o stays set until clear_i.
- Spurious fir_valid_strobe_i in IDLE and in ISSUE -> no m_valid_o, counters unchanged.
- Assert rst_i asynchronously (mid-cycle) during WAIT with 3 samples queued -> all outputs 0 and FIFO empty immediately; a late FIR strobe after release produces nothing.
- FIR latency 1 with m_ready_i=1, 4 samples queued -> strobes every 3 cycles; each last_latency_o=1.
